seq_detector_1011: RTL

SEQ_DETECTOR_1011 -- requirements
Module: seq_detector_1011

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/dff_bank.sv | 25 ++
 rtl/seq_detector_1011.sv | 89 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 serial pattern detector: state encoding,
// counter width/limit and the pattern itself.
package seq_det_pkg;

    // Width and saturation value of the detection counter
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    // Pattern being searched for, first bit received is the MSB
    localparam logic [3:0] PATTERN = 4'b1011;

    // Width of the state register; codes 101..111 are unused
    localparam int STATE_W = 3;

    // Detector states, named after the prefix of PATTERN matched so far
    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,   // nothing matched
        S1 = 3'b001,   // "1"
        S2 = 3'b010,   // "10"
        S3 = 3'b011,   // "101"
        S4 = 3'b100    // "1011" found
    } state_e;

    // True for the five codes that name a real state
    function automatic logic isLegalState(input logic [STATE_W-1:0] code);
        return (code <= S4);
    endfunction

endpackage

// File: rtl/dff_bank.sv
// Generic bank of N rising-edge D flip-flops with an asynchronous
// active-low clear. Holds no logic of its own beyond storage.
module dff_bank #(
    parameter int N = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] bank_q;

    // Capture d_i on every rising edge; clear to zero as soon as rst_ni drops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q <= '0;
        end else begin
            bank_q <= d_i;
        end
    end

    assign q_o = bank_q;

endmodule

// File: rtl/seq_detector_1011.sv
// Overlapping 1011 serial pattern detector with a Moore detect flag and a
// saturating detection counter. Storage lives in two dff_bank instances;
// all next-state, counter and output decode logic is kept here.
module seq_detector_1011
    import seq_det_pkg::*;
(
    input  logic             CLK,
    input  logic             CLR_b,
    input  logic             X,
    input  logic             EN,
    input  logic             CNT_CLR,
    output logic             Z,
    output logic [CNT_W-1:0] CNT,
    output logic             SAT
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               detect;

    // State register: a plain bank of flops cleared by CLR_b
    dff_bank #(
        .N (STATE_W)
    ) u_state_bank (
        .clk_i  (CLK),
        .rst_ni (CLR_b),
        .d_i    (state_d),
        .q_o    (state_q)
    );

    // Detection counter register, cleared by CLR_b alongside the state
    dff_bank #(
        .N (CNT_W)
    ) u_cnt_bank (
        .clk_i  (CLK),
        .rst_ni (CLR_b),
        .d_i    (cnt_d),
        .q_o    (cnt_q)
    );

    // Next-state logic: advance on enabled edges, hold otherwise, and pull
    // any unused code back to S0 whether or not EN is set
    always_comb begin
        state_d = S0;
        if (!isLegalState(state_q)) begin
            state_d = S0;
        end else if (!EN) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S0:      state_d = X ? S1 : S0;
                S1:      state_d = X ? S1 : S2;
                S2:      state_d = X ? S3 : S0;
                S3:      state_d = X ? S4 : S2;
                S4:      state_d = X ? S1 : S2;
                default: state_d = S0;
            endcase
        end
    end

    // A detection is exactly the enabled S3 -> S4 move on a final 1
    always_comb begin
        detect = 1'b0;
        if (EN && (state_q == S3) && (X == PATTERN[0])) begin
            detect = 1'b1;
        end
    end

    // Counter update: synchronous clear beats an increment on the same
    // edge, and the count sticks at CNT_MAX once reached
    always_comb begin
        cnt_d = cnt_q;
        if (CNT_CLR) begin
            cnt_d = '0;
        end else if (detect && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs decode only registered values so X and EN never reach them
    always_comb begin
        Z   = (state_q == S4);
        CNT = cnt_q;
        SAT = (cnt_q == CNT_MAX);
    end

endmodule
